// File: rtl/cic_capture_pkg.sv
// Shared types and defaults for the CIC capture controller.
package cic_capture_pkg;

    // Capture sequencer states. The S_ prefix keeps the literals apart from
    // the FLUSH length parameter of the top module.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Default record length and number of start-up beats to discard.
    localparam int DEFAULT_DEPTH = 1300;
    localparam int DEFAULT_FLUSH = 4;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
    parameter int DEPTH  = 1300,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Index only as wide as the array needs; addresses beyond DEPTH alias,
    // which is acceptable because their read data is undefined anyway.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              unused_addr_bits;

    assign wr_idx           = wr_addr[IDX_W-1:0];
    assign rd_idx           = rd_addr[IDX_W-1:0];
    assign unused_addr_bits = ^{wr_addr, rd_addr};

    // Write port; contents are deliberately left unreset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read, read-before-write on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/cic_capture_ctrl.sv
// Captures a fixed-length record of truncated CIC output samples into a
// buffer, after discarding the filter start-up transient.
module cic_capture_ctrl
    import cic_capture_pkg::*;
#(
    parameter int IN_W    = 54,
    parameter int OUT_W   = 16,
    parameter int MSB_SEL = 53,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDR_W  = 11,
    parameter int FLUSH   = DEFAULT_FLUSH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cic_valid,
    input  logic [1:0]        cic_error,
    input  logic [IN_W-1:0]   cic_data,
    output logic              cic_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              err_flag,
    output logic [ADDR_W-1:0] count
);

    localparam int FC_W = (FLUSH < 2) ? 1 : $clog2(FLUSH + 1);

    state_t            state_reg, state_next;
    logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic [ADDR_W-1:0] count_reg, count_next;
    logic              err_reg, err_next;
    logic              ready_reg, ready_next;
    logic              beat;
    logic              wr_en;
    logic [OUT_W-1:0]  sample;
    logic              unused_data_bits;

    // Plain truncation: the stored word keeps the two's complement sign bit.
    assign sample           = cic_data[MSB_SEL -: OUT_W];
    assign unused_data_bits = ^cic_data;
    assign beat             = cic_valid && ready_reg;

    assign cic_ready = ready_reg;
    assign busy      = (state_reg == S_FLUSH) || (state_reg == S_CAPTURE);
    assign done      = (state_reg == S_DONE);
    assign err_flag  = err_reg;
    assign count     = count_reg;

    // State, counters and the registered ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            flush_cnt_reg <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            count_reg     <= count_next;
            err_reg       <= err_next;
            ready_reg     <= ready_next;
        end
    end

    // Next-state and counter logic; abort overrides everything, including the write.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        count_next     = count_reg;
        err_next       = err_reg;
        wr_en          = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next     = (FLUSH > 0) ? S_FLUSH : S_CAPTURE;
                        flush_cnt_next = '0;
                        count_next     = '0;
                        err_next       = 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (beat) begin
                        flush_cnt_next = flush_cnt_reg + FC_W'(1);
                        if (flush_cnt_reg == FC_W'(FLUSH - 1)) begin
                            state_next = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (beat) begin
                        wr_en      = 1'b1;
                        count_next = count_reg + ADDR_W'(1);
                        if (cic_error != 2'b00) begin
                            err_next = 1'b1;
                        end
                        if (count_reg == ADDR_W'(DEPTH - 1)) begin
                            state_next = S_DONE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
        ready_next = (state_next == S_FLUSH) || (state_next == S_CAPTURE);
    end

    capture_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (OUT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (count_reg),
        .wr_data (sample),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_cic_capture_ctrl.sv
// Directed bench for cic_capture_ctrl with a short record (DEPTH=8, FLUSH=4).
module tb_cic_capture_ctrl;

    localparam int IN_W   = 54;
    localparam int OUT_W  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              cic_valid;
    logic [1:0]        cic_error;
    logic [IN_W-1:0]   cic_data;
    logic              cic_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              err_flag;
    logic [ADDR_W-1:0] count;

    int checks = 0;
    int errors = 0;

    cic_capture_ctrl #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .MSB_SEL (53),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .FLUSH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cic_valid (cic_valid),
        .cic_error (cic_error),
        .cic_data  (cic_data),
        .cic_ready (cic_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err_flag  (err_flag),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IN_W-1:0] word(input logic [15:0] top);
        return {top, 38'd0};
    endfunction

    task automatic read_chk(input string tag, input int addr, input logic [15:0] exp);
        rd_addr = ADDR_W'(addr);
        tick();
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cic_valid = 1'b0; cic_error = 2'b00; cic_data = '0; rd_addr = '0;
        tick();
        chk("rst_ready", 64'(cic_ready), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(err_flag),  64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_rddata",64'(rd_data),   64'd0);
        reset = 1'b0;
        tick();

        // Record 1: valid held high, beat i carries i in the top 16 bits.
        start = 1'b1; tick(); start = 1'b0;
        chk("a_busy",  64'(busy),      64'd1);
        chk("a_ready", 64'(cic_ready), 64'd1);
        cic_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cic_data = word(16'(i));
            tick();
            if (i == 4) chk("a_count_first", 64'(count), 64'd1);
            if (i == 10) chk("a_done_early", 64'(done), 64'd0);
        end
        chk("a_done",  64'(done),      64'd1);
        chk("a_ready0",64'(cic_ready), 64'd0);
        chk("a_count", 64'(count),     64'd8);
        chk("a_err",   64'(err_flag),  64'd0);
        cic_data = word(16'hBEEF);
        tick();
        chk("a_count_hold", 64'(count), 64'd8);
        cic_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) read_chk("a_buf", a, 16'(a + 4));

        // Record 2: valid toggling 1-0-1-0, off-beat data must never be stored.
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            cic_valid = (c % 2 == 0);
            cic_data  = word(16'(c + 32));
            tick();
            if (c == 8)  chk("b_count_c8",  64'(count), 64'd1);
            if (c == 9)  chk("b_count_c9",  64'(count), 64'd1);
            if (c == 21) chk("b_count_c21", 64'(count), 64'd7);
            if (c == 21) chk("b_done_c21",  64'(done),  64'd0);
            if (c == 22) chk("b_done_c22",  64'(done),  64'd1);
        end
        chk("b_count", 64'(count), 64'd8);
        cic_valid = 1'b0;
        for (int j = 0; j < DEPTH; j++) read_chk("b_buf", j, 16'(40 + 2 * j));

        // Record 3: errored flush beat ignored, errored capture beat sticky.
        start = 1'b1; tick(); start = 1'b0;
        cic_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            cic_error = (f == 1) ? 2'b01 : 2'b00;
            cic_data  = word(16'h7777);
            tick();
        end
        chk("c_err_flush", 64'(err_flag), 64'd0);
        for (int j = 0; j < DEPTH; j++) begin
            cic_error = (j == 2) ? 2'b01 : 2'b00;
            if (j == 0)      cic_data = 54'h3FFFC000000000;
            else if (j == 2) cic_data = word(16'h1234);
            else             cic_data = word(16'(16'h200 + j));
            tick();
            if (j == 1) chk("c_err_before", 64'(err_flag), 64'd0);
            if (j == 2) chk("c_err_set",    64'(err_flag), 64'd1);
        end
        cic_error = 2'b00;
        chk("c_done", 64'(done), 64'd1);
        tick();
        chk("c_err_sticky", 64'(err_flag), 64'd1);
        cic_valid = 1'b0;
        read_chk("c_buf_neg", 0, 16'hFFFF);
        chk("c_neg_signed", 64'($signed(rd_data) == -16'sd1), 64'd1);
        read_chk("c_buf_err", 2, 16'h1234);
        read_chk("c_buf_last", 7, 16'h0207);

        // Record 4: abort at count 5, write suppressed on the abort cycle.
        start = 1'b1; tick(); start = 1'b0;
        chk("d_err_clr",   64'(err_flag), 64'd0);
        chk("d_count_clr", 64'(count),    64'd0);
        cic_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin cic_data = '0; tick(); end
        for (int j = 0; j < 5; j++) begin
            cic_error = (j == 1) ? 2'b10 : 2'b00;
            cic_data  = word(16'(16'h300 + j));
            tick();
        end
        cic_error = 2'b00;
        chk("d_count5", 64'(count),    64'd5);
        chk("d_err1",   64'(err_flag), 64'd1);
        abort = 1'b1; cic_data = word(16'hDEAD); tick(); abort = 1'b0;
        chk("d_ab_busy",  64'(busy),      64'd0);
        chk("d_ab_ready", 64'(cic_ready), 64'd0);
        chk("d_ab_count", 64'(count),     64'd5);
        chk("d_ab_err",   64'(err_flag),  64'd1);
        tick();
        chk("d_idle_ready", 64'(cic_ready), 64'd0);
        chk("d_idle_done",  64'(done),      64'd0);
        read_chk("d_buf5_kept", 5, 16'h0205);
        read_chk("d_buf4", 4, 16'h0304);
        start = 1'b1; tick(); start = 1'b0;
        chk("d_rs_count", 64'(count),    64'd0);
        chk("d_rs_err",   64'(err_flag), 64'd0);
        chk("d_rs_busy",  64'(busy),     64'd1);
        // A start inside FLUSH must not restart the flush.
        for (int f = 0; f < 4; f++) begin start = (f == 1); cic_data = '0; tick(); end
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin cic_data = word(16'(16'h400 + j)); tick(); end
        chk("d_start_ign", 64'(count), 64'd2);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("d_sa_busy",  64'(busy),  64'd0);
        chk("d_sa_count", 64'(count), 64'd2);
        tick();
        chk("d_sa_idle",  64'(busy),  64'd0);

        // Reset in the middle of a capture.
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < 7; b++) begin cic_data = word(16'(16'h500 + b)); tick(); end
        chk("e_count3", 64'(count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("e_rst_ready", 64'(cic_ready), 64'd0);
        chk("e_rst_busy",  64'(busy),      64'd0);
        chk("e_rst_count", 64'(count),     64'd0);
        chk("e_rst_rd",    64'(rd_data),   64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("e_idle_busy", 64'(busy), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("e_st_count", 64'(count), 64'd0);
        chk("e_st_busy",  64'(busy),  64'd1);
        for (int b = 0; b < 5; b++) begin cic_data = word(16'(16'h600 + b)); tick(); end
        chk("e_count1", 64'(count), 64'd1);
        cic_valid = 1'b0;
        read_chk("e_buf0", 0, 16'h0604);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_capture_ctrl.md
Name: cic_capture_ctrl

Overview:
Sequences capture of the decimated CIC output stream into an on-chip sample buffer for offline analysis, e.g. first-stage verification of the 77.5 kHz receive path. Sits on the CIC Avalon-ST source and acts as its sink. Discards the CIC start-up transient, truncates each 54-bit output word to 16 bits and stores a fixed-length record. Exposes a synchronous read port for the host/readout logic.

Parameters:
IN_W, 54, CIC output word width
OUT_W, 16, stored sample width; sample = cic_data[MSB_SEL -: OUT_W]
MSB_SEL, 53, top bit of truncation window (IN_W-1 >= MSB_SEL >= OUT_W-1)
DEPTH, 1300, samples per record
ADDR_W, 11, buffer address width (2**ADDR_W >= DEPTH)
FLUSH, 4, valid beats discarded after start (CIC transient); 0 allowed

Ports:
clk  in  1  system clock (130 MHz)
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin a record (ignored unless IDLE or DONE)
abort  in  1  one-cycle pulse: stop capture, return to IDLE
cic_valid  in  1  Avalon-ST valid from CIC
cic_error  in  2  Avalon-ST error from CIC; nonzero = corrupt beat
cic_data  in  IN_W  Avalon-ST data from CIC (signed)
cic_ready  out  1  Avalon-ST ready to CIC
rd_addr  in  ADDR_W  buffer read address
rd_data  out  OUT_W  buffer read data, 1-cycle latency
busy  out  1  high in FLUSH or CAPTURE
done  out  1  high in DONE (record complete)
err_flag  out  1  sticky: an errored beat was seen during this record
count  out  ADDR_W  samples stored in current record

Behaviour:
- Reset (async assert, sync release): state=IDLE; cic_ready=0, busy=0, done=0, err_flag=0, count=0, flush counter=0; rd_data=0. Buffer contents are not reset.
- Beat = cycle with cic_valid && cic_ready. Only beats advance counters.
- States:
  IDLE: cic_ready=0. start -> FLUSH if FLUSH>0, else CAPTURE. Clear count, err_flag, flush counter on the same edge.
  FLUSH: cic_ready=1. Each beat increments flush counter, no write. On the FLUSH-th beat -> CAPTURE. Errored beats in FLUSH are discarded and do not set err_flag.
  CAPTURE: cic_ready=1. Each beat writes cic_data[MSB_SEL -: OUT_W] to buf[count] and increments count. Beat with cic_error!=0 is still written and sets err_flag. Beat that makes count==DEPTH -> DONE on that edge.
  DONE: cic_ready=0. count holds DEPTH, done=1. start -> new record as from IDLE.
- cic_ready is a registered function of state. First beat accepted is in the cycle after entering FLUSH/CAPTURE. In DONE, no beat is accepted even if valid is held.
- abort: highest priority. From any state -> IDLE next edge; no write on that cycle; count and err_flag hold for inspection. start and abort together: abort wins.
- start while FLUSH/CAPTURE: ignored.
- Truncation: plain bit-select, no rounding or saturation. Stored value is signed two's complement.
- Read port: rd_data <= buf[rd_addr] every clock, independent of state. Read of the same address written this cycle returns old data. rd_addr >= DEPTH returns undefined data.
- Write-to-readable latency: a sample written on edge k is readable with rd_addr applied at edge k+1 and appears on rd_data after edge k+1.

Decomposition:
- Package cic_capture_pkg: state enum (IDLE, FLUSH, CAPTURE, DONE), default DEPTH/FLUSH constants.
- One sub-module: capture_ram (simple dual-port, 1 write/1 registered read, DEPTH x OUT_W), inferable as block RAM.
- FSM, counters and truncation stay in the top.

Test Plan:
- Reset mid-CAPTURE (count=37): assert reset -> outputs 0 immediately, state IDLE; after release, start records from count=0.
- FLUSH=4, DEPTH=8, valid held high, data=i<<38 on beat i -> buf[0..7]=4..11, done=1 after 12th beat, cic_ready=0 after; err_flag=0.
- Valid toggling 1-0-1-0 with DEPTH=8 -> exactly 8 writes, count steps only on beats, done after 16 cycles of stream (+flush).
- Negative data: cic_data=54'h3FFFC000000000 (top 16 bits 0xFFFF) -> rd_data=16'hFFFF. Signed value -1 preserved.
- cic_error=2'b01 on 3rd capture beat -> sample still stored, err_flag=1 and sticky until next start; error during FLUSH -> err_flag stays 0.
- abort at count=5, then start -> IDLE for one cycle, count holds 5, err_flag holds; restart clears both; simultaneous start+abort in CAPTURE -> IDLE.
